// File: rtl/block_stream_pkg.sv
// Shared encodings for the begin/end keyword stream transmitter:
// command ops, FSM states, ASCII constants and word lengths.
package block_stream_pkg;

    typedef enum logic [1:0] {
        OP_OPEN  = 2'd0,
        OP_CLOSE = 2'd1,
        OP_FILL  = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    localparam logic [7:0] CH_SPACE   = 8'h20;
    localparam logic [7:0] CASE_DELTA = 8'h20;

    // Beat counts include the trailing space
    localparam logic [2:0] LEN_OPEN  = 3'd6;
    localparam logic [2:0] LEN_CLOSE = 3'd4;
    localparam logic [2:0] LEN_FILL  = 3'd2;

endpackage

// File: rtl/block_word_rom.sv
// Character tables for the command words: maps (op, index, case) to the
// ASCII character at that index and flags the word's final character.
module block_word_rom
    import block_stream_pkg::*;
(
    input  op_e        op,
    input  logic [2:0] idx,
    input  logic       upper,
    output logic [7:0] ch,
    output logic       last
);

    logic [7:0] lower_ch;
    logic [2:0] len;

    always_comb begin
        lower_ch = CH_SPACE;
        len      = LEN_FILL;
        case (op)
            OP_OPEN: begin
                len = LEN_OPEN;
                case (idx)
                    3'd0:    lower_ch = 8'h62;
                    3'd1:    lower_ch = 8'h65;
                    3'd2:    lower_ch = 8'h67;
                    3'd3:    lower_ch = 8'h69;
                    3'd4:    lower_ch = 8'h6E;
                    default: lower_ch = CH_SPACE;
                endcase
            end
            OP_CLOSE: begin
                len = LEN_CLOSE;
                case (idx)
                    3'd0:    lower_ch = 8'h65;
                    3'd1:    lower_ch = 8'h6E;
                    3'd2:    lower_ch = 8'h64;
                    default: lower_ch = CH_SPACE;
                endcase
            end
            OP_FILL: begin
                len = LEN_FILL;
                lower_ch = (idx == 3'd0) ? 8'h78 : CH_SPACE;
            end
            default: begin
                len      = 3'd1;
                lower_ch = CH_SPACE;
            end
        endcase
        // Only letters fold; the separator is always a plain space
        ch   = (upper && lower_ch != CH_SPACE) ? lower_ch - CASE_DELTA : lower_ch;
        last = (idx == len - 3'd1);
    end

endmodule

// File: rtl/block_stream_gen.sv
// Serialises OPEN/CLOSE/FILL commands into "begin "/"end "/"x " characters
// over a valid/ready stream, tracking nesting depth and a sticky error.
module block_stream_gen
    import block_stream_pkg::*;
#(
    parameter int DEPTH_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic               cmd_upper,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_char,
    output logic [DEPTH_W-1:0] depth,
    output logic               err,
    output logic               balanced
);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

    state_e               state_reg, state_next;
    op_e                  op_reg, op_next;
    logic                 upper_reg, upper_next;
    logic [2:0]           idx_reg, idx_next;
    logic [7:0]           char_reg, char_next;
    logic                 last_reg, last_next;
    logic [DEPTH_W-1:0]   depth_reg, depth_next;
    logic                 err_reg, err_next;

    // One lookup port: the first character while idle, the following one while emitting
    op_e        rom_op;
    logic [2:0] rom_idx;
    logic       rom_upper;
    logic [7:0] rom_ch;
    logic       rom_last;

    assign rom_op    = (state_reg == ST_EMIT) ? op_reg : op_e'(cmd_op);
    assign rom_idx   = (state_reg == ST_EMIT) ? idx_reg + 3'd1 : 3'd0;
    assign rom_upper = (state_reg == ST_EMIT) ? upper_reg : cmd_upper;

    block_word_rom u_rom (
        .op    (rom_op),
        .idx   (rom_idx),
        .upper (rom_upper),
        .ch    (rom_ch),
        .last  (rom_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            op_reg    <= OP_OPEN;
            upper_reg <= 1'b0;
            idx_reg   <= 3'd0;
            char_reg  <= CH_SPACE;
            last_reg  <= 1'b0;
            depth_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            upper_reg <= upper_next;
            idx_reg   <= idx_next;
            char_reg  <= char_next;
            last_reg  <= last_next;
            depth_reg <= depth_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        upper_next = upper_reg;
        idx_next   = idx_reg;
        char_next  = char_reg;
        last_next  = last_reg;
        depth_next = depth_reg;
        err_next   = err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_next    = op_e'(cmd_op);
                    upper_next = cmd_upper;
                    idx_next   = 3'd0;
                    // Depth is booked at accept; an unmatched CLOSE is still emitted
                    case (op_e'(cmd_op))
                        OP_OPEN: begin
                            if (depth_reg == DEPTH_MAX) err_next = 1'b1;
                            else depth_next = depth_reg + DEPTH_W'(1);
                        end
                        OP_CLOSE: begin
                            if (depth_reg == '0) err_next = 1'b1;
                            else depth_next = depth_reg - DEPTH_W'(1);
                        end
                        OP_FILL: ;
                        default: err_next = 1'b1;
                    endcase
                    if (op_e'(cmd_op) != OP_RSVD) begin
                        state_next = ST_EMIT;
                        char_next  = rom_ch;
                        last_next  = rom_last;
                    end
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (last_reg) begin
                        state_next = ST_IDLE;
                    end else begin
                        idx_next  = idx_reg + 3'd1;
                        char_next = rom_ch;
                        last_next = rom_last;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign cmd_ready = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_EMIT);
    assign out_char  = char_reg;
    assign depth     = depth_reg;
    assign err       = err_reg;
    assign balanced  = (depth_reg == '0) && !err_reg;

endmodule

// File: tb/tb_block_stream_gen.sv
// Directed and randomized checks of block_stream_gen against a word-level
// model; a second instance with a 2-bit depth counter covers overflow.
module tb_block_stream_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_upper;
    logic       out_ready;

    logic       cmd_ready, out_valid, err, balanced;
    logic [7:0] out_char;
    logic [7:0] depth;

    logic       cmd_ready2, out_valid2, err2, balanced2;
    logic [7:0] out_char2;
    logic [1:0] depth2;

    block_stream_gen #(.DEPTH_W(8)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_upper(cmd_upper), .out_valid(out_valid),
        .out_ready(out_ready), .out_char(out_char), .depth(depth),
        .err(err), .balanced(balanced)
    );

    block_stream_gen #(.DEPTH_W(2)) dut2 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
        .cmd_op(cmd_op), .cmd_upper(cmd_upper), .out_valid(out_valid2),
        .out_ready(out_ready), .out_char(out_char2), .depth(depth2),
        .err(err2), .balanced(balanced2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference state: nesting depth and sticky error for both counter widths
    int m_depth, m_err, m_depth2, m_err2;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build_word(input int op, input bit up);
        string s;
        logic [7:0] c;
        case (op)
            0:       s = "begin ";
            1:       s = "end ";
            2:       s = "x ";
            default: s = "";
        endcase
        exp_q.delete();
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (up && c != 8'h20) c = c - 8'h20;
            exp_q.push_back(c);
        end
    endtask

    task automatic model_accept(input int op);
        case (op)
            0: begin
                if (m_depth == 255) m_err = 1; else m_depth++;
                if (m_depth2 == 3) m_err2 = 1; else m_depth2++;
            end
            1: begin
                if (m_depth == 0) m_err = 1; else m_depth--;
                if (m_depth2 == 0) m_err2 = 1; else m_depth2--;
            end
            2: ;
            default: begin
                m_err  = 1;
                m_err2 = 1;
            end
        endcase
    endtask

    task automatic check_status(input string tag);
        check({tag, "_depth"}, depth, m_depth);
        check({tag, "_err"}, err, m_err);
        check({tag, "_balanced"}, balanced, (m_depth == 0 && m_err == 0));
        check({tag, "_depth2"}, depth2, m_depth2);
        check({tag, "_err2"}, err2, m_err2);
        check({tag, "_balanced2"}, balanced2, (m_depth2 == 0 && m_err2 == 0));
    endtask

    task automatic model_reset();
        m_depth = 0; m_err = 0; m_depth2 = 0; m_err2 = 0;
    endtask

    // Called at 1 time unit after a rising edge with the block idle.
    // mode: 0 = out_ready held high, 1 = pattern 1,0,0 repeating, 2 = random
    task automatic run_cmd(input int op, input bit up, input int mode);
        int  k;
        int  cyc;
        bit  rdy;
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_upper = up;
        out_ready = 1'b0;
        @(posedge clk); #1;
        model_accept(op);
        build_word(op, up);
        // Commands offered during emission must be ignored
        cmd_valid = (mode == 2) ? 1'($urandom) : 1'b0;
        cmd_op    = 2'($urandom);
        cmd_upper = 1'($urandom);
        check_status("accept");
        check("out_valid_after_accept", out_valid, exp_q.size() != 0);
        k = 0;
        cyc = 0;
        while (k < exp_q.size() && cyc < 200) begin
            check("out_valid_emit", out_valid, 1);
            check("cmd_ready_emit", cmd_ready, 0);
            check("out_char", out_char, exp_q[k]);
            check("out_char2", out_char2, exp_q[k]);
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom);
            out_ready = rdy;
            @(posedge clk); #1;
            if (rdy) k++;
            cyc++;
            if (mode == 2) cmd_valid = 1'($urandom);
        end
        if (cyc >= 200) check("emit_timeout", 0, 1);
        cmd_valid = 1'b0;
        out_ready = 1'b0;
        check("out_valid_done", out_valid, 0);
        check("cmd_ready_done", cmd_ready, 1);
        check_status("done");
        $display("cmd op=%0d upper=%0d beats=%0d cycles=%0d depth=%0d err=%0d depth2=%0d err2=%0d",
                 op, up, k, cyc, depth, err, depth2, err2);
    endtask

    initial begin
        int op;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_upper = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_char", out_char, 8'h20);
        check_status("rst");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Lowercase OPEN at full rate, then the nested upper-case sequence
        run_cmd(0, 1'b0, 0);
        run_cmd(1, 1'b0, 0);
        run_cmd(0, 1'b1, 0);
        run_cmd(2, 1'b1, 0);
        run_cmd(1, 1'b1, 0);

        // Unmatched CLOSE makes err stick through a balanced pair
        run_cmd(1, 1'b0, 0);
        run_cmd(0, 1'b0, 0);
        run_cmd(1, 1'b0, 0);

        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        check_status("clr");

        // Backpressure: beats only on the high ready cycles
        run_cmd(0, 1'b0, 1);
        run_cmd(1, 1'b0, 1);

        // Four OPENs saturate the 2-bit instance
        for (int i = 0; i < 4; i++) run_cmd(0, 1'b0, 0);
        for (int i = 0; i < 4; i++) run_cmd(1, 1'b0, 0);

        // Reserved op: accepted with no beats
        run_cmd(3, 1'b0, 0);

        // Asynchronous reset in the middle of the third beat
        check("cmd_ready_pre_async", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_upper = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("async_pre_char", out_char, 8'h67);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("async_out_valid", out_valid, 0);
        check("async_cmd_ready", cmd_ready, 1);
        check("async_out_char", out_char, 8'h20);
        check_status("async");
        out_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        run_cmd(0, 1'b0, 0);
        run_cmd(1, 1'b0, 2);

        // Randomized commands with random backpressure
        for (int n = 0; n < 60; n++) begin
            if (n == 30) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                model_reset();
            end
            op = $urandom_range(0, 9);
            op = (op < 4) ? 0 : (op < 7) ? 1 : (op < 9) ? 2 : 3;
            run_cmd(op, 1'($urandom), 2);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
